// File: rtl/sec_stream_miter.sv
// -----------------------------------------------------------------------------
// sec_stream_miter
//   Sequential-equivalence miter for two output streams (A = ILA model,
//   B = spec RTL) driven by the same stimulus. Beats from the side that fires
//   first are held in a circular skew buffer. Each held beat is checked in
//   order against the matching beat from the other side. Mismatch, buffer
//   overflow and skew timeout all set a sticky error. After an error the
//   block freezes until reset.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   a_valid/a_ready/a_data   model A stream (fires on a_valid & a_ready)
//   b_valid/b_ready/b_data   model B stream (fires on b_valid & b_ready)
//   cmp_mask              1 = bit takes part in the compare
//   equiv                 1 while no error has been recorded
//   err, err_code         sticky error flag; code 0 none, 1 mismatch,
//                         2 overflow, 3 timeout
//   err_a_data/err_b_data the two beats of the first mismatch
//   beat_cnt              number of compared pairs, saturating
//   pend_cnt              number of beats held in the skew buffer
// -----------------------------------------------------------------------------
module sec_stream_miter #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 8,
    parameter int MAX_SKEW = 16,
    parameter int CNT_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_valid,
    input  logic                       a_ready,
    input  logic [DATA_W-1:0]          a_data,
    input  logic                       b_valid,
    input  logic                       b_ready,
    input  logic [DATA_W-1:0]          b_data,
    input  logic [DATA_W-1:0]          cmp_mask,
    output logic                       equiv,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [DATA_W-1:0]          err_a_data,
    output logic [DATA_W-1:0]          err_b_data,
    output logic [CNT_W-1:0]           beat_cnt,
    output logic [$clog2(DEPTH+1)-1:0] pend_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH+1);
    localparam int TW = (MAX_SKEW > 0) ? $clog2(MAX_SKEW+1) : 1;

    localparam logic [PW-1:0] FULL     = PW'(DEPTH);
    localparam logic [PW-1:0] ONE      = PW'(1);
    localparam logic [TW-1:0] SKEW_LIM = TW'(MAX_SKEW);

    typedef enum logic [1:0] {
        BAL    = 2'd0,
        A_LEAD = 2'd1,
        B_LEAD = 2'd2,
        ERR    = 2'd3
    } state_e;

    localparam logic [1:0] CODE_NONE = 2'd0;
    localparam logic [1:0] CODE_MISM = 2'd1;
    localparam logic [1:0] CODE_OVF  = 2'd2;
    localparam logic [1:0] CODE_TMO  = 2'd3;

    state_e              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       pend_cnt_q, pend_cnt_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [DATA_W-1:0]   err_a_data_q, err_a_data_d;
    logic [DATA_W-1:0]   err_b_data_q, err_b_data_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                fa, fb;
    logic                push, pop, do_cmp, mism, ovf, tmo;
    logic [DATA_W-1:0]   push_data, cmp_x, cmp_y, head;

    assign fa   = a_valid & a_ready;
    assign fb   = b_valid & b_ready;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        pend_cnt_d   = pend_cnt_q;
        timer_d      = timer_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        err_a_data_d = err_a_data_q;
        err_b_data_d = err_b_data_q;
        beat_cnt_d   = beat_cnt_q;
        push         = 1'b0;
        pop          = 1'b0;
        do_cmp       = 1'b0;
        ovf          = 1'b0;
        tmo          = 1'b0;
        push_data    = a_data;
        cmp_x        = a_data;
        cmp_y        = b_data;

        case (state_q)
            BAL: begin
                timer_d = '0;
                if (fa && fb) begin
                    do_cmp = 1'b1;
                end else if (fa) begin
                    push    = 1'b1;
                    state_d = A_LEAD;
                end else if (fb) begin
                    push      = 1'b1;
                    push_data = b_data;
                    state_d   = B_LEAD;
                end
            end
            A_LEAD: begin
                // Buffer holds A beats; the head is the A side of the compare.
                cmp_x  = head;
                pop    = fb;
                do_cmp = fb;
                push   = fa;
                if (fa && !fb && pend_cnt_q == FULL) begin
                    ovf  = 1'b1;
                    push = 1'b0;
                end
                if (fb && !fa && pend_cnt_q == ONE) state_d = BAL;
            end
            B_LEAD: begin
                // Buffer holds B beats; the head is the B side of the compare.
                cmp_y     = head;
                push_data = b_data;
                pop       = fa;
                do_cmp    = fa;
                push      = fb;
                if (fb && !fa && pend_cnt_q == FULL) begin
                    ovf  = 1'b1;
                    push = 1'b0;
                end
                if (fa && !fb && pend_cnt_q == ONE) state_d = BAL;
            end
            default: ;  // ERR: frozen until reset
        endcase

        // The skew timer measures how long the current head has waited.
        // A pop hands the wait over to a newer beat, so the timer restarts.
        if (state_q == A_LEAD || state_q == B_LEAD) begin
            if (pop) begin
                timer_d = '0;
            end else if (MAX_SKEW > 0) begin
                timer_d = timer_q + TW'(1);
                tmo     = (timer_d == SKEW_LIM);
            end
        end

        mism = do_cmp && (((cmp_x ^ cmp_y) & cmp_mask) != '0);

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        pend_cnt_d = pend_cnt_q + PW'(push) - PW'(pop);

        if (do_cmp && beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + CNT_W'(1);

        if (mism || ovf || tmo) begin
            state_d = ERR;
            err_d   = 1'b1;
            if (mism) begin
                err_code_d   = CODE_MISM;
                err_a_data_d = cmp_x;
                err_b_data_d = cmp_y;
            end else if (ovf) begin
                err_code_d = CODE_OVF;
            end else begin
                err_code_d = CODE_TMO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BAL;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pend_cnt_q   <= '0;
            timer_q      <= '0;
            err_q        <= 1'b0;
            err_code_q   <= CODE_NONE;
            err_a_data_q <= '0;
            err_b_data_q <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pend_cnt_q   <= pend_cnt_d;
            timer_q      <= timer_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            err_a_data_q <= err_a_data_d;
            err_b_data_q <= err_b_data_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Buffer storage needs no reset: the pointers and pend_cnt decide what is live.
    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= push_data;
    end

    assign equiv      = ~err_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign err_a_data = err_a_data_q;
    assign err_b_data = err_b_data_q;
    assign beat_cnt   = beat_cnt_q;
    assign pend_cnt   = pend_cnt_q;

endmodule

// File: tb/tb_sec_stream_miter.sv
module tb_sec_stream_miter;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 32;
    localparam int PW     = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid, a_ready, b_valid, b_ready;
    logic [DATA_W-1:0] a_data, b_data, cmp_mask;
    logic              equiv, err;
    logic [1:0]        err_code;
    logic [DATA_W-1:0] err_a_data, err_b_data;
    logic [CNT_W-1:0]  beat_cnt;
    logic [PW-1:0]     pend_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    sec_stream_miter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_SKEW(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .cmp_mask(cmp_mask),
        .equiv(equiv), .err(err), .err_code(err_code),
        .err_a_data(err_a_data), .err_b_data(err_b_data),
        .beat_cnt(beat_cnt), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 1'b0; a_ready = 1'b1; a_data = '0;
        b_valid = 1'b0; b_ready = 1'b1; b_data = '0;
    endtask

    task automatic drive(input logic av, input logic [DATA_W-1:0] ad,
                         input logic bv, input logic [DATA_W-1:0] bd);
        a_valid = av; a_ready = 1'b1; a_data = ad;
        b_valid = bv; b_ready = 1'b1; b_data = bd;
    endtask

    task automatic do_reset();
        idle();
        cmp_mask = '1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        cmp_mask = '1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_tests++; if (equiv !== 1'b1) begin n_fail++; $display("FAIL rst_equiv: got %b exp 1", equiv); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b exp 0", err); end
        n_tests++; if (err_code !== 2'd0) begin n_fail++; $display("FAIL rst_code: got %0d exp 0", err_code); end
        n_tests++; if (err_a_data !== '0 || err_b_data !== '0) begin n_fail++; $display("FAIL rst_errdata: got %h/%h exp 0/0", err_a_data, err_b_data); end
        n_tests++; if (beat_cnt !== '0) begin n_fail++; $display("FAIL rst_beat: got %0d exp 0", beat_cnt); end
        n_tests++; if (pend_cnt !== '0) begin n_fail++; $display("FAIL rst_pend: got %0d exp 0", pend_cnt); end
    endtask

    task automatic test_lockstep();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, {32'(i), ~32'(i)}, 1'b1, {32'(i), ~32'(i)});
            tick();
        end
        // valid without ready (and ready without valid) must not fire
        a_valid = 1'b1; a_ready = 1'b0; a_data = 64'h1;
        b_valid = 1'b0; b_ready = 1'b1; b_data = 64'h2;
        tick();
        idle();
        tick();
        n_tests++; if (beat_cnt !== 32'd100) begin n_fail++; $display("FAIL lock_beat: got %0d exp 100", beat_cnt); end
        n_tests++; if (pend_cnt !== '0) begin n_fail++; $display("FAIL lock_pend: got %0d exp 0", pend_cnt); end
        n_tests++; if (equiv !== 1'b1) begin n_fail++; $display("FAIL lock_equiv: got %b exp 1", equiv); end
    endtask

    task automatic test_b_lag();
        int max_pend = 0;
        do_reset();
        for (int t = 0; t < 23; t++) begin
            drive(t < 20, 64'(t + 1), (t >= 3) && (t < 23), 64'(t - 2));
            tick();
            if (int'(pend_cnt) > max_pend) max_pend = int'(pend_cnt);
        end
        idle();
        tick();
        n_tests++; if (max_pend != 3) begin n_fail++; $display("FAIL lag_peak: got %0d exp 3", max_pend); end
        n_tests++; if (pend_cnt !== '0) begin n_fail++; $display("FAIL lag_pend: got %0d exp 0", pend_cnt); end
        n_tests++; if (equiv !== 1'b1) begin n_fail++; $display("FAIL lag_equiv: got %b exp 1", equiv); end
        n_tests++; if (beat_cnt !== 32'd20) begin n_fail++; $display("FAIL lag_beat: got %0d exp 20", beat_cnt); end
    endtask

    // B leads by 5 with 12 distinct beats, so the buffer pointers wrap.
    task automatic test_b_lead_wrap();
        int max_pend = 0;
        do_reset();
        for (int t = 0; t < 17; t++) begin
            drive((t >= 5), 64'h100 + 64'(t - 5), (t < 12), 64'h100 + 64'(t));
            tick();
            if (int'(pend_cnt) > max_pend) max_pend = int'(pend_cnt);
        end
        idle();
        tick();
        n_tests++; if (max_pend != 5) begin n_fail++; $display("FAIL blead_peak: got %0d exp 5", max_pend); end
        n_tests++; if (beat_cnt !== 32'd12) begin n_fail++; $display("FAIL blead_beat: got %0d exp 12", beat_cnt); end
        n_tests++; if (equiv !== 1'b1 || pend_cnt !== '0) begin n_fail++; $display("FAIL blead_end: got equiv %b pend %0d exp 1/0", equiv, pend_cnt); end
    endtask

    task automatic test_mismatch();
        do_reset();
        drive(1'b1, 64'hDEAD, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b1, 64'hBEEF);
        tick();
        idle();
        n_tests++; if (err !== 1'b1 || equiv !== 1'b0) begin n_fail++; $display("FAIL mm_flag: got err %b equiv %b exp 1/0", err, equiv); end
        n_tests++; if (err_code !== 2'd1) begin n_fail++; $display("FAIL mm_code: got %0d exp 1", err_code); end
        n_tests++; if (err_a_data !== 64'hDEAD) begin n_fail++; $display("FAIL mm_adata: got %h exp dead", err_a_data); end
        n_tests++; if (err_b_data !== 64'hBEEF) begin n_fail++; $display("FAIL mm_bdata: got %h exp beef", err_b_data); end
        n_tests++; if (beat_cnt !== 32'd1) begin n_fail++; $display("FAIL mm_beat: got %0d exp 1", beat_cnt); end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 64'h1111, (i % 2) == 0, 64'h2222);
            tick();
        end
        idle();
        tick();
        n_tests++; if (err_code !== 2'd1 || err_a_data !== 64'hDEAD || err_b_data !== 64'hBEEF) begin
            n_fail++; $display("FAIL mm_frozen: got %0d %h %h exp 1 dead beef", err_code, err_a_data, err_b_data); end
        n_tests++; if (beat_cnt !== 32'd1 || pend_cnt !== '0) begin n_fail++; $display("FAIL mm_frozen_cnt: got beat %0d pend %0d exp 1/0", beat_cnt, pend_cnt); end
    endtask

    task automatic test_mask();
        do_reset();
        cmp_mask = 64'hFFFF_FFFF_FFFF_FF00;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h1234_5678_9ABC_DE00 + 64'(i), 1'b1, 64'h1234_5678_9ABC_DEA5 ^ 64'(i));
            tick();
        end
        drive(1'b1, 64'hAAAA_0000_0000_00FF, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b1, 64'hAAAA_0000_0000_0000);
        tick();
        idle();
        n_tests++; if (equiv !== 1'b1 || beat_cnt !== 32'd5) begin n_fail++; $display("FAIL mask_low: got equiv %b beat %0d exp 1/5", equiv, beat_cnt); end
        // bit 8 is the lowest compared bit
        drive(1'b1, 64'h0000_0000_0000_0100, 1'b1, 64'h0);
        tick();
        idle();
        n_tests++; if (err_code !== 2'd1 || equiv !== 1'b0) begin n_fail++; $display("FAIL mask_bit8: got code %0d equiv %b exp 1/0", err_code, equiv); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'(i + 1), 1'b0, '0);
            tick();
        end
        n_tests++; if (pend_cnt !== PW'(8) || err !== 1'b0) begin n_fail++; $display("FAIL ovf_full: got pend %0d err %b exp 8/0", pend_cnt, err); end
        // push+pop while full is legal; the partner of the head (1) arrives
        drive(1'b1, 64'd9, 1'b1, 64'd1);
        tick();
        n_tests++; if (pend_cnt !== PW'(8) || err !== 1'b0) begin n_fail++; $display("FAIL ovf_pushpop: got pend %0d err %b exp 8/0", pend_cnt, err); end
        drive(1'b1, 64'd10, 1'b0, '0);
        tick();
        idle();
        n_tests++; if (err_code !== 2'd2 || err !== 1'b1) begin n_fail++; $display("FAIL ovf_code: got %0d err %b exp 2/1", err_code, err); end
        n_tests++; if (err_a_data !== '0) begin n_fail++; $display("FAIL ovf_nodata: got %h exp 0", err_a_data); end
    endtask

    task automatic test_timeout();
        do_reset();
        drive(1'b1, 64'h77, 1'b0, '0);
        tick();
        idle();
        for (int i = 0; i < 15; i++) tick();
        n_tests++; if (err !== 1'b0 || pend_cnt !== PW'(1)) begin n_fail++; $display("FAIL tmo_early: got err %b pend %0d exp 0/1", err, pend_cnt); end
        tick();
        n_tests++; if (err_code !== 2'd3 || equiv !== 1'b0) begin n_fail++; $display("FAIL tmo_code: got %0d equiv %b exp 3/0", err_code, equiv); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'(i + 40), 1'b0, '0);
            tick();
        end
        idle();
        n_tests++; if (pend_cnt !== PW'(5)) begin n_fail++; $display("FAIL rmid_pend5: got %0d exp 5", pend_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (pend_cnt !== '0 || beat_cnt !== '0 || equiv !== 1'b1) begin
            n_fail++; $display("FAIL rmid_clear: got pend %0d beat %0d equiv %b exp 0/0/1", pend_cnt, beat_cnt, equiv); end
        // stale A beats must be gone: a lone B beat now leads
        drive(1'b0, '0, 1'b1, 64'h5);
        tick();
        idle();
        n_tests++; if (pend_cnt !== PW'(1) || err !== 1'b0) begin n_fail++; $display("FAIL rmid_stale: got pend %0d err %b exp 1/0", pend_cnt, err); end
        drive(1'b1, 64'h6, 1'b0, '0);
        tick();
        idle();
        n_tests++; if (err_code !== 2'd1 || err_a_data !== 64'h6 || err_b_data !== 64'h5) begin
            n_fail++; $display("FAIL rmid_bmm: got %0d %h %h exp 1 6 5", err_code, err_a_data, err_b_data); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (err !== 1'b0 || err_code !== 2'd0 || err_a_data !== '0 || err_b_data !== '0 || beat_cnt !== '0 || pend_cnt !== '0) begin
            n_fail++; $display("FAIL rmid_err_clear: got err %b code %0d a %h b %h beat %0d pend %0d", err, err_code, err_a_data, err_b_data, beat_cnt, pend_cnt); end
        // block operates normally again after leaving ERR
        drive(1'b1, 64'h9, 1'b1, 64'h9);
        tick();
        idle();
        n_tests++; if (beat_cnt !== 32'd1 || equiv !== 1'b1) begin n_fail++; $display("FAIL rmid_resume: got beat %0d equiv %b exp 1/1", beat_cnt, equiv); end
    endtask

    initial begin
        rst = 1'b1;
        cmp_mask = '1;
        idle();
        test_reset();
        test_lockstep();
        test_b_lag();
        test_b_lead_wrap();
        test_mismatch();
        test_mask();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
